mavg_filter_core: RTL and testbench

MAVG_FILTER_CORE -- requirements
Module: mavg_filter_core

---
 rtl/mavg_filter_core.sv | 134 +++++++++++++
 tb/tb_mavg_filter_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mavg_filter_core.sv
// ----------------------------------------------------------------------------
// mavg_filter_core
//   Multi-channel moving-window filter. Each channel keeps the last N = 2^LOG2_N
//   accepted samples and a running sum of them. On every accepted sample the
//   per-channel result register loads one of: window mean, sum clamped to the
//   sample range, the raw new sample, or zero. The result appears one clock
//   after acceptance, marked by a single-cycle out_valid pulse.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset (assert any time, release synced)
//   in_valid   : sample strobe, in_data accepted on each edge where high
//   in_data    : CH packed unsigned samples, channel c at [c*W +: W]
//   mode       : 00 mean, 01 saturated sum, 10 bypass, 11 zero
//   clear      : synchronous flush of history, sums, count, result, out_valid
//   out_en     : combinational output gate, 0 forces out_data to zero
//   out_valid  : one-cycle pulse marking a new result
//   out_data   : CH packed per-channel results
//   full       : high once N samples have been accepted since reset/clear
// ----------------------------------------------------------------------------
module mavg_filter_core #(
    parameter int W      = 2,
    parameter int LOG2_N = 2,
    parameter int CH     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CH*W-1:0]   in_data,
    input  logic [1:0]        mode,
    input  logic              clear,
    input  logic              out_en,
    output logic              out_valid,
    output logic [CH*W-1:0]   out_data,
    output logic              full
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = W + LOG2_N;   // holds N*(2^W-1) exactly

    // A sample is taken only when no flush is requested on the same edge.
    logic accept;
    assign accept = in_valid && !clear;

    // ------------------------------------------------------------------------
    // Fill counter and out_valid pulse (shared by all channels)
    // ------------------------------------------------------------------------
    logic [LOG2_N:0] count_q, count_d;
    logic            out_valid_q, out_valid_d;

    always_comb begin
        count_d     = count_q;
        out_valid_d = accept;
        if (clear) begin
            count_d = '0;
        end else if (in_valid && (count_q != (LOG2_N+1)'(N))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign full      = (count_q == (LOG2_N+1)'(N));
    assign out_valid = out_valid_q;

    // ------------------------------------------------------------------------
    // Per-channel history, running sum and result register
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < CH; gi++) begin : ch_g
        logic [W-1:0]  hist_q [N];
        logic [W-1:0]  hist_d [N];
        logic [SW-1:0] sum_q, sum_d;
        logic [SW-1:0] sum_next;
        logic [W-1:0]  res_q, res_d;
        logic [W-1:0]  sample;

        assign sample = in_data[gi*W +: W];

        // Intermediate wrap in the subtraction is harmless: the true result
        // always fits in SW bits, so modular arithmetic lands on it exactly.
        assign sum_next = sum_q + SW'(sample) - SW'(hist_q[N-1]);

        always_comb begin
            hist_d = hist_q;
            sum_d  = sum_q;
            res_d  = res_q;
            if (clear) begin
                for (int i = 0; i < N; i++) begin
                    hist_d[i] = '0;
                end
                sum_d = '0;
                res_d = '0;
            end else if (in_valid) begin
                hist_d[0] = sample;
                for (int i = 1; i < N; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                sum_d = sum_next;
                case (mode)
                    2'b00:   res_d = sum_next[SW-1:LOG2_N];
                    2'b01:   res_d = (sum_next > SW'({W{1'b1}})) ? {W{1'b1}}
                                                                : sum_next[W-1:0];
                    2'b10:   res_d = sample;
                    default: res_d = '0;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    hist_q[i] <= '0;
                end
                sum_q <= '0;
                res_q <= '0;
            end else begin
                hist_q <= hist_d;
                sum_q  <= sum_d;
                res_q  <= res_d;
            end
        end

        assign out_data[gi*W +: W] = res_q & {W{out_en}};
    end

endmodule

// File: tb/tb_mavg_filter_core.sv
// ----------------------------------------------------------------------------
// tb_mavg_filter_core
//   Self-checking bench for mavg_filter_core (W=2, LOG2_N=2, CH=3). A window
//   model kept as plain integer arrays predicts every output; directed
//   sequences add explicit constant checks, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_mavg_filter_core;

    localparam int W      = 2;
    localparam int LOG2_N = 2;
    localparam int CH     = 3;
    localparam int N      = 1 << LOG2_N;
    localparam int MAXV   = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [CH*W-1:0]   in_data;
    logic [1:0]        mode;
    logic              clear;
    logic              out_en;
    logic              out_valid;
    logic [CH*W-1:0]   out_data;
    logic              full;

    mavg_filter_core #(.W(W), .LOG2_N(LOG2_N), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .clear     (clear),
        .out_en    (out_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .full      (full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int  m_hist [CH][N];
    int  m_res  [CH];
    int  m_cnt;
    bit  m_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++) m_hist[c][i] = 0;
            m_res[c] = 0;
        end
        m_cnt   = 0;
        m_valid = 0;
    endtask

    // Window semantics: newest at index 0, empty slots are zero, sum is the
    // plain total of the window.
    task automatic model_edge(input bit v, input logic [CH*W-1:0] d,
                              input logic [1:0] m, input bit c_clr);
        if (c_clr) begin
            model_reset();
            return;
        end
        m_valid = v;
        if (!v) return;
        if (m_cnt < N) m_cnt++;
        for (int c = 0; c < CH; c++) begin
            int s;
            int smp;
            smp = int'(d[c*W +: W]);
            for (int i = N-1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
            m_hist[c][0] = smp;
            s = 0;
            for (int i = 0; i < N; i++) s += m_hist[c][i];
            case (m)
                2'b00:   m_res[c] = s / N;
                2'b01:   m_res[c] = (s > MAXV) ? MAXV : s;
                2'b10:   m_res[c] = smp;
                default: m_res[c] = 0;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ":valid"}, 32'(out_valid), 32'(m_valid));
        check_eq({tag, ":full"},  32'(full), 32'(m_cnt == N));
        for (int c = 0; c < CH; c++)
            check_eq({tag, ":data"}, 32'(out_data[c*W +: W]), out_en ? 32'(m_res[c]) : 32'd0);
    endtask

    // Drive one cycle, update the model on the edge, check 1 time unit later.
    task automatic step(input string tag, input bit v, input logic [CH*W-1:0] d,
                        input logic [1:0] m, input bit c_clr, input bit oe);
        in_valid = v;
        in_data  = d;
        mode     = m;
        clear    = c_clr;
        out_en   = oe;
        @(posedge clk);
        model_edge(v, d, m, c_clr);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [CH*W-1:0] pack(input int a0, input int a1, input int a2);
        logic [CH*W-1:0] r;
        r = '0;
        r[0*W +: W] = W'(a0);
        r[1*W +: W] = W'(a1);
        r[2*W +: W] = W'(a2);
        return r;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(MAXV, 0));
    endfunction

    initial begin
        int e33 [5];
        int s34 [6];
        int e34 [6];

        rst_n = 1'b0; in_valid = 0; in_data = '0; mode = 2'b00; clear = 0; out_en = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Mean warm-up on ch0
        e33 = '{0, 1, 2, 3, 2};
        for (int i = 0; i < 5; i++) begin
            step("mean_warm", 1, pack((i < 4) ? 3 : 0, rnd(), rnd()), 2'b00, 0, 1);
            check_eq("req33_ch0", 32'(out_data[1:0]), 32'(e33[i]));
            check_eq("req33_full", 32'(full), 32'(i >= 3));
        end

        // Saturated sum on ch1
        step("clr", 0, '0, 2'b00, 1, 1);
        s34 = '{1, 2, 0, 0, 0, 0};
        e34 = '{1, 3, 3, 3, 2, 0};
        for (int i = 0; i < 6; i++) begin
            step("satsum", 1, pack(rnd(), s34[i], rnd()), 2'b01, 0, 1);
            check_eq("req34_ch1", 32'(out_data[3:2]), 32'(e34[i]));
        end

        // Bypass, zero, then mean proves history still updated
        step("clr", 0, '0, 2'b00, 1, 1);
        step("bypass", 1, pack(rnd(), rnd(), 2), 2'b10, 0, 1);
        check_eq("req35_byp", 32'(out_data[5:4]), 32'd2);
        step("zero", 1, pack(rnd(), rnd(), 1), 2'b11, 0, 1);
        check_eq("req35_zero", 32'(out_data), 32'd0);
        step("mean", 1, pack(rnd(), rnd(), 0), 2'b00, 0, 1);
        check_eq("req35_mean", 32'(out_data[5:4]), 32'd0);

        // Clear colliding with a valid sample
        step("clr", 0, '0, 2'b00, 1, 1);
        for (int i = 0; i < 4; i++) step("fill", 1, pack(3, 3, 3), 2'b00, 0, 1);
        check_eq("req36_full_before", 32'(full), 32'd1);
        step("clr_coll", 1, pack(3, 3, 3), 2'b00, 1, 1);
        check_eq("req36_valid", 32'(out_valid), 32'd0);
        check_eq("req36_full", 32'(full), 32'd0);
        check_eq("req36_data", 32'(out_data), 32'd0);
        step("after_clr", 1, pack(3, 3, 3), 2'b00, 0, 1);
        check_eq("req36_next", 32'(out_data[1:0]), 32'd0);

        // Output gating while holding
        step("clr", 0, '0, 2'b00, 1, 1);
        for (int i = 0; i < 4; i++) step("fill", 1, pack(3, 3, 3), 2'b00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step("hold", 0, pack(rnd(), rnd(), rnd()), 2'(i), 0, i[0]);
            check_eq("req37_ch0", 32'(out_data[1:0]), i[0] ? 32'd3 : 32'd0);
            check_eq("req37_valid", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset pulse between edges
        step("pre_rst", 1, pack(3, 3, 3), 2'b00, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("req38_full", 32'(full), 32'd0);
        check_eq("req38_valid", 32'(out_valid), 32'd0);
        check_eq("req38_data", 32'(out_data), 32'd0);
        #1 rst_n = 1'b1;
        step("post_rst", 1, pack(3, 3, 3), 2'b00, 0, 1);
        check_eq("req38_next", 32'(out_data[1:0]), 32'd0);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(3, 0) != 0),
                 pack(rnd(), rnd(), rnd()), 2'($urandom_range(3, 0)),
                 ($urandom_range(19, 0) == 0), ($urandom_range(7, 0) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
